sprite_cmd_encoder: RTL

Command-side counterpart of the sprite display blocks. It accepts high-level sprite update requests (target component, visibility, flip, X, Y, attributes) and frame-commit pulses from the game/control logic. It serialises them into the 32-bit command words the sprite display components decode: `{component[5:0], child[4:0], action[3:0], action_type[2:0], buffer_toggle, action_data[12:0]}`. It tracks the display back buffer so that all updates land in the hidden buffer and each commit swaps buffers.

---
 rtl/sprite_cmd_encoder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sprite_cmd_encoder.sv
// sprite_cmd_encoder: serialises sprite update requests and frame commits into
// 32-bit sprite display command words, keeping all updates in the hidden
// (back) buffer and swapping buffers on each commit.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready request handshake; req_component/child/visible/flip/
//                       x/y/attr request payload
//   commit, commit_component  frame-commit pulse and the component to swap
//   wr_valid/wr_ready   command word handshake; writedata command word
//   back_buf            buffer index currently being written
//   busy                FIFO non-empty, sequence in flight or commit pending
module sprite_cmd_encoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_component,
  input  logic [4:0]  req_child,
  input  logic        req_visible,
  input  logic        req_flip,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  input  logic [9:0]  req_attr,
  input  logic        commit,
  input  logic [5:0]  commit_component,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] writedata,
  output logic        back_buf,
  output logic        busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [3:0]  ACT_UPDATE = 4'h1;
  localparam logic [3:0]  ACT_COMMIT = 4'hF;

  typedef struct packed {
    logic [5:0] component;
    logic [4:0] child;
    logic       visible;
    logic       flip;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] attr;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VIS,
    S_XPOS,
    S_YPOS,
    S_ATTR,
    S_COMMIT
  } state_t;

  state_t           state_q, state_d;
  req_t             cur_q, cur_d;
  req_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             commit_pending_q, commit_pending_d;
  logic [5:0]       commit_comp_q, commit_comp_d;
  logic             back_buf_q, back_buf_d;
  logic             wr_valid_q, wr_valid_d;
  logic [31:0]      writedata_q, writedata_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;

  req_t req_in;
  req_t head;
  logic push;
  logic fifo_empty;
  logic take;
  logic fifo_wr;
  logic fifo_rd;
  logic handshake;
  logic commit_seen;

  // Command word for the state about to be presented
  function automatic logic [31:0] build_word(input state_t st, input req_t r,
                                             input logic tog, input logic [5:0] comp);
    logic [31:0] w;
    w = 32'h0;
    case (st)
      S_VIS:    w = {r.component, r.child, ACT_UPDATE, 3'b001, tog, r.visible, r.flip, 11'b0};
      S_XPOS:   w = {r.component, r.child, ACT_UPDATE, 3'b010, tog, 3'b000, r.x};
      S_YPOS:   w = {r.component, r.child, ACT_UPDATE, 3'b011, tog, 3'b000, r.y};
      S_ATTR:   w = {r.component, r.child, ACT_UPDATE, 3'b100, tog, 3'b000, r.attr};
      S_COMMIT: w = {comp, 5'b00000, ACT_COMMIT, 3'b000, tog, 13'b0};
      default:  w = 32'h0;
    endcase
    return w;
  endfunction

  // Next-state, FIFO bookkeeping and registered-output computation
  always_comb begin
    req_in = '{component: req_component, child: req_child, visible: req_visible,
               flip: req_flip, x: req_x, y: req_y, attr: req_attr};
    push        = req_valid && req_ready_q;
    fifo_empty  = (count_q == '0);
    // An empty FIFO hands the incoming request straight to the sequencer
    head        = fifo_empty ? req_in : mem_q[rd_ptr_q];
    handshake   = wr_valid_q && wr_ready;
    commit_seen = commit_pending_q || commit;

    state_d = state_q;
    cur_d   = cur_q;
    take    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty || push) begin
          state_d = S_VIS;
          take    = 1'b1;
        end else if (commit_seen) begin
          state_d = S_COMMIT;
        end
      end
      S_VIS:  if (handshake) state_d = S_XPOS;
      S_XPOS: if (handshake) state_d = S_YPOS;
      S_YPOS: if (handshake) state_d = S_ATTR;
      S_ATTR: begin
        if (handshake) begin
          if (!fifo_empty) begin
            state_d = S_VIS;
            take    = 1'b1;
          end else if (commit_pending_q) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_COMMIT: if (handshake) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (take) cur_d = head;

    fifo_rd = take && !fifo_empty;
    fifo_wr = push && !(take && fifo_empty);

    wr_ptr_d = fifo_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = fifo_rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (fifo_wr && !fifo_rd) begin
      count_d = count_q + CNT_W'(1);
    end else if (fifo_rd && !fifo_wr) begin
      count_d = count_q - CNT_W'(1);
    end

    commit_pending_d = commit_pending_q;
    commit_comp_d    = commit_comp_q;
    back_buf_d       = back_buf_q;
    // Pulses while a commit is already pending are dropped
    if (commit && !commit_pending_q) begin
      commit_pending_d = 1'b1;
      commit_comp_d    = commit_component;
    end
    if ((state_q == S_COMMIT) && handshake) begin
      commit_pending_d = 1'b0;
      back_buf_d       = !back_buf_q;
    end

    wr_valid_d  = (state_d != S_IDLE);
    writedata_d = build_word(state_d, cur_d, back_buf_d, commit_comp_d);
    req_ready_d = (count_d != CNT_W'(FIFO_DEPTH)) && !commit_pending_d;
    busy_d      = (count_d != '0) || (state_d != S_IDLE) || commit_pending_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cur_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      commit_pending_q <= 1'b0;
      commit_comp_q    <= '0;
      back_buf_q       <= 1'b1;
      wr_valid_q       <= 1'b0;
      writedata_q      <= 32'h0;
      req_ready_q      <= 1'b1;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_q            <= cur_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      commit_pending_q <= commit_pending_d;
      commit_comp_q    <= commit_comp_d;
      back_buf_q       <= back_buf_d;
      wr_valid_q       <= wr_valid_d;
      writedata_q      <= writedata_d;
      req_ready_q      <= req_ready_d;
      busy_q           <= busy_d;
    end
  end

  // Request storage; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (!reset && fifo_wr) mem_q[wr_ptr_q] <= req_in;
  end

  assign req_ready = req_ready_q;
  assign wr_valid  = wr_valid_q;
  assign writedata = writedata_q;
  assign back_buf  = back_buf_q;
  assign busy      = busy_q;

endmodule
